// File: rtl/multi_counter.sv
// Bank of up/down counters sharing one prescaled tick, with per-channel load
// and a global wrap/saturate bound mode.
module multi_counter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1,
    parameter int PW       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [CHANNELS-1:0]       cen,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       wen,
    input  logic [WIDTH-1:0]          dat,
    input  logic                      sat,
    output logic [CHANNELS*WIDTH-1:0] cnt_o,
    output logic [CHANNELS-1:0]       tc_o,
    output logic                      tick_o
);

    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [PW-1:0]       r_pre;
    logic [PW-1:0]       w_pre_nxt;
    logic                w_tick;
    logic [WIDTH-1:0]    r_cnt     [CHANNELS];
    logic [WIDTH-1:0]    w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] r_tc;
    logic [CHANNELS-1:0] w_tc_nxt;

    // With PRESCALE=1 the register never leaves 0, so the tick is always high.
    assign w_tick = (r_pre == PRE_LAST);

    always_comb begin
        w_pre_nxt = r_pre + PW'(1);
        if (clr || w_tick) begin
            w_pre_nxt = '0;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_tc_nxt[i]  = 1'b0;
            if (clr) begin
                w_cnt_nxt[i] = '0;
            end else if (wen[i]) begin
                w_cnt_nxt[i] = dat;
            end else if (cen[i] && w_tick) begin
                if (!dir[i]) begin
                    if (r_cnt[i] == MAX) begin
                        w_tc_nxt[i]  = 1'b1;
                        w_cnt_nxt[i] = sat ? MAX : '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + ONE;
                    end
                end else begin
                    if (r_cnt[i] == '0) begin
                        w_tc_nxt[i]  = 1'b1;
                        w_cnt_nxt[i] = sat ? '0 : MAX;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_tc  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_pre <= w_pre_nxt;
            r_tc  <= w_tc_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign cnt_o[g*WIDTH +: WIDTH] = r_cnt[g];
    end

    assign tc_o   = r_tc;
    assign tick_o = w_tick;

endmodule

// File: tb/tb_multi_counter.sv
// Scoreboard bench for multi_counter: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_multi_counter;

    typedef struct {
        bit          sel;
        logic [31:0] cnt;
        logic [3:0]  tc;
        logic        tick;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_a, rst_b;
    logic        clr, sat;
    logic [3:0]  cen, dir, wen;
    logic [7:0]  dat;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  tc_a, tc_b;
    logic        tick_a, tick_b;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    multi_counter #(.WIDTH(8), .CHANNELS(4), .PRESCALE(1), .PW(8)) u_a (
        .clk(clk), .rst(rst_a), .clr(clr), .cen(cen), .dir(dir), .wen(wen),
        .dat(dat), .sat(sat), .cnt_o(cnt_a), .tc_o(tc_a), .tick_o(tick_a)
    );

    multi_counter #(.WIDTH(8), .CHANNELS(4), .PRESCALE(4), .PW(8)) u_b (
        .clk(clk), .rst(rst_b), .clr(clr), .cen(cen), .dir(dir), .wen(wen),
        .dat(dat), .sat(sat), .cnt_o(cnt_b), .tc_o(tc_b), .tick_o(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got stalled bench, required completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [31:0] c;
            logic [3:0]  t;
            logic        k;
            e = q.pop_front();
            c = e.sel ? cnt_b  : cnt_a;
            t = e.sel ? tc_b   : tc_a;
            k = e.sel ? tick_b : tick_a;
            checks++;
            if (c !== e.cnt || t !== e.tc || k !== e.tick) begin
                errors++;
                $display("FAIL %s: got cnt=%h tc=%b tick=%b, required cnt=%h tc=%b tick=%b",
                         e.name, c, t, k, e.cnt, e.tc, e.tick);
            end
        end
    end

    task automatic step(input bit sel, input logic [31:0] ecnt, input logic [3:0] etc,
                        input logic etick, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.sel = sel; e.cnt = ecnt; e.tc = etc; e.tick = etick; e.name = nm;
        q.push_back(e);
    endtask

    task automatic direct_check(input logic [35:0] got, input logic [35:0] want, input string nm);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        clr = 1'b0; sat = 1'b0; cen = 4'h0; dir = 4'h0; wen = 4'h0; dat = 8'h00;

        // ---------------- instance A, PRESCALE=1 ----------------
        step(0, 32'h0000_0000, 4'h0, 1'b1, "reset_state");
        rst_a = 1'b0;
        cen = 4'b0001;
        for (int k = 1; k <= 5; k++) step(0, 32'(k), 4'h0, 1'b1, "ch0_count_up");
        cen = 4'h0;
        step(0, 32'h0000_0005, 4'h0, 1'b1, "hold");

        wen = 4'b0010; dat = 8'hFE;
        step(0, 32'h0000_FE05, 4'h0, 1'b1, "load_ch1_wrap");
        wen = 4'h0; cen = 4'b0010; sat = 1'b0;
        step(0, 32'h0000_FF05, 4'h0, 1'b1, "wrap_ff");
        step(0, 32'h0000_0005, 4'h2, 1'b1, "wrap_to_00_tc");
        step(0, 32'h0000_0105, 4'h0, 1'b1, "wrap_01");

        wen = 4'b0010; cen = 4'h0; sat = 1'b1;
        step(0, 32'h0000_FE05, 4'h0, 1'b1, "load_ch1_sat");
        wen = 4'h0; cen = 4'b0010;
        step(0, 32'h0000_FF05, 4'h0, 1'b1, "sat_reach_ff");
        step(0, 32'h0000_FF05, 4'h2, 1'b1, "sat_hold_tc1");
        step(0, 32'h0000_FF05, 4'h2, 1'b1, "sat_hold_tc2");

        cen = 4'b0100; dir = 4'b0100; sat = 1'b0;
        step(0, 32'h00FF_FF05, 4'h4, 1'b1, "down_wrap_tc");
        step(0, 32'h00FE_FF05, 4'h0, 1'b1, "down_fe");
        cen = 4'b1000; dir = 4'b1000; sat = 1'b1;
        step(0, 32'h00FE_FF05, 4'h8, 1'b1, "down_sat_zero");

        wen = 4'b0001; cen = 4'b0001; dir = 4'h0; dat = 8'h10;
        step(0, 32'h00FE_FF10, 4'h0, 1'b1, "load_beats_step");
        cen = 4'h0; dat = 8'h42;
        step(0, 32'h00FE_FF42, 4'h0, 1'b1, "load_42");
        wen = 4'h0; cen = 4'b1001; dir = 4'b1000; sat = 1'b1;
        step(0, 32'h00FE_FF43, 4'h8, 1'b1, "mixed_step");
        clr = 1'b1; cen = 4'hF; wen = 4'hF; dat = 8'h77;
        step(0, 32'h0000_0000, 4'h0, 1'b1, "clr_priority");
        clr = 1'b0; wen = 4'h0; cen = 4'b1001; dir = 4'b1000; sat = 1'b1;
        step(0, 32'h0000_0001, 4'h8, 1'b1, "after_clr");

        @(negedge clk);
        #2 rst_a = 1'b1;
        #1 direct_check({tc_a, cnt_a}, 36'h0, "async_reset");
        cen = 4'h0; dir = 4'h0; sat = 1'b0;

        // ---------------- instance B, PRESCALE=4 ----------------
        @(posedge clk);
        #1;
        rst_b = 1'b0; cen = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            logic [7:0] v;
            v = 8'(k / 4);
            step(1, {4{v}}, 4'h0, (k % 4) == 3, "pre4_count");
        end
        cen = 4'h0;
        step(1, 32'h0303_0303, 4'h0, 1'b0, "pre4_hold1");
        step(1, 32'h0303_0303, 4'h0, 1'b0, "pre4_hold2");
        step(1, 32'h0303_0303, 4'h0, 1'b1, "pre4_hold3_tick");
        wen = 4'b0001; cen = 4'hF; dat = 8'h10;
        step(1, 32'h0404_0410, 4'h0, 1'b0, "pre4_load_wins");
        wen = 4'h0; cen = 4'h0;
        step(1, 32'h0404_0410, 4'h0, 1'b0, "pre4_pre1");
        clr = 1'b1;
        step(1, 32'h0000_0000, 4'h0, 1'b0, "pre4_clr");
        clr = 1'b0;
        step(1, 32'h0000_0000, 4'h0, 1'b0, "pre4_restart1");
        step(1, 32'h0000_0000, 4'h0, 1'b0, "pre4_restart2");
        step(1, 32'h0000_0000, 4'h0, 1'b1, "pre4_restart_tick");

        repeat (2) @(negedge clk);
        direct_check(36'(q.size()), 36'h0, "scoreboard_drained");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
